// File: rtl/transmissor_16.sv
// UART transmitter for 16-bit words: two back-to-back frames, high byte first,
// LSB first within each byte, optional even parity, one stop bit.
module transmissor_16 #(
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned CLOCK_HZ  = 50_000_000,
  parameter int unsigned PARITY    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [15:0] data_in,
  output logic        tx_serial,
  output logic        ocupado,
  output logic        fim_transmitir,
  output logic [3:0]  db_estado
);

  localparam int unsigned BIT_T = CLOCK_HZ / BAUD_RATE;
  localparam int unsigned CW    = $clog2(BIT_T);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_T - 1);

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    PREPARA  = 4'd1,
    INICIO   = 4'd2,
    DADOS    = 4'd3,
    PARIDADE = 4'd4,
    PARADA   = 4'd5,
    FIM      = 4'd6
  } state_t;

  state_t          state, state_n;
  logic [15:0]     word, word_n;
  logic [7:0]      shift, shift_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [CW-1:0]   baud, baud_n;
  logic            low_sel, low_sel_n;
  logic            tx, tx_n;
  logic            tick;
  logic            byte_par;

  assign tick     = (baud == BAUD_LAST);
  assign byte_par = low_sel ? ^word[7:0] : ^word[15:8];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= OCIOSO;
      word    <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      baud    <= '0;
      low_sel <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      word    <= word_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      baud    <= baud_n;
      low_sel <= low_sel_n;
      tx      <= tx_n;
    end
  end

  // tx_n carries the level of the bit being entered, so the line changes
  // on the same edge as the state and stays registered.
  always_comb begin
    state_n   = state;
    word_n    = word;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    low_sel_n = low_sel;
    tx_n      = tx;
    baud_n    = tick ? '0 : baud + 1'b1;
    unique case (state)
      OCIOSO: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (partida) begin
          word_n    = data_in;
          low_sel_n = 1'b0;
          state_n   = PREPARA;
        end
      end
      PREPARA: begin
        baud_n    = '0;
        shift_n   = word[15:8];
        bit_cnt_n = '0;
        tx_n      = 1'b0;
        state_n   = INICIO;
      end
      INICIO: begin
        if (tick) begin
          state_n   = DADOS;
          tx_n      = shift[0];
          bit_cnt_n = '0;
        end
      end
      DADOS: begin
        if (tick) begin
          if (bit_cnt == 3'd7) begin
            if (PARITY != 0) begin
              state_n = PARIDADE;
              tx_n    = byte_par;
            end else begin
              state_n = PARADA;
              tx_n    = 1'b1;
            end
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      PARIDADE: begin
        if (tick) begin
          state_n = PARADA;
          tx_n    = 1'b1;
        end
      end
      PARADA: begin
        if (tick) begin
          if (!low_sel) begin
            low_sel_n = 1'b1;
            shift_n   = word[7:0];
            tx_n      = 1'b0;
            state_n   = INICIO;
          end else begin
            state_n = FIM;
            tx_n    = 1'b1;
          end
        end
      end
      FIM: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (partida) begin
          word_n    = data_in;
          low_sel_n = 1'b0;
          state_n   = PREPARA;
        end else begin
          state_n = OCIOSO;
        end
      end
      default: begin
        baud_n  = '0;
        tx_n    = 1'b1;
        state_n = OCIOSO;
      end
    endcase
  end

  assign tx_serial      = tx;
  assign ocupado        = (state != OCIOSO) && (state != FIM);
  assign fim_transmitir = (state == FIM);
  assign db_estado      = state;

endmodule
